// File: rtl/uart_shift_link.sv
// 8N1 UART transceiver with a parameterised staging shift register.
// Both baud ticks come from free-running dividers of the single system clock.
module uart_shift_link #(
  parameter int CLK_FREQ       = 50_000_000,
  parameter int BAUD           = 115200,
  parameter int SR_INPUT_WIDTH = 32,
  parameter int SR_DATA_WIDTH  = 32,
  parameter int SR_SHIFT_WIDTH = 8
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic [7:0]                din,
  input  logic                      wr_en,
  output logic                      tx,
  output logic                      tx_busy,
  input  logic                      rx,
  output logic                      rdy,
  input  logic                      rdy_clr,
  output logic [7:0]                dout,
  input  logic [SR_INPUT_WIDTH-1:0] sr_in,
  input  logic                      sr_load,
  input  logic                      sr_shift,
  output logic [SR_DATA_WIDTH-1:0]  sr_out
);

  localparam int TX_DIV = CLK_FREQ / BAUD;
  localparam int RX_DIV = CLK_FREQ / (16 * BAUD);
  localparam int TX_CW  = (TX_DIV > 1) ? $clog2(TX_DIV) : 1;
  localparam int RX_CW  = (RX_DIV > 1) ? $clog2(RX_DIV) : 1;

  typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_t;
  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;

  logic [TX_CW-1:0] tx_cnt_r;
  logic [RX_CW-1:0] rx_cnt_r;
  logic             tx_tick_s;
  logic             rx_tick_s;

  tx_state_t  tx_state_r, tx_state_nxt_s;
  logic [7:0] tx_shreg_r, tx_shreg_nxt_s;
  logic [2:0] tx_bit_r, tx_bit_nxt_s;
  logic       tx_lead_r, tx_lead_nxt_s;
  logic       tx_r, tx_nxt_s;
  logic       tx_busy_r, tx_busy_nxt_s;

  logic       rx_meta_r, rx_sync_r;
  rx_state_t  rx_state_r, rx_state_nxt_s;
  logic [3:0] rx_tcnt_r, rx_tcnt_nxt_s;
  logic [2:0] rx_bit_r, rx_bit_nxt_s;
  logic [7:0] rx_shreg_r, rx_shreg_nxt_s;
  logic       rx_done_s;
  logic [7:0] dout_r;
  logic       rdy_r;

  logic [SR_DATA_WIDTH-1:0] sr_r;
  logic [SR_DATA_WIDTH-1:0] sr_load_val_s;

  assign tx_tick_s = (tx_cnt_r == TX_CW'(TX_DIV - 1));
  assign rx_tick_s = (rx_cnt_r == RX_CW'(RX_DIV - 1));

  // Free-running baud dividers
  always_ff @(posedge clock) begin
    if (!reset) begin
      tx_cnt_r <= '0;
      rx_cnt_r <= '0;
    end else begin
      tx_cnt_r <= tx_tick_s ? '0 : tx_cnt_r + TX_CW'(1);
      rx_cnt_r <= rx_tick_s ? '0 : rx_cnt_r + RX_CW'(1);
    end
  end

  // TX state and registered line/busy outputs
  always_ff @(posedge clock) begin
    if (!reset) begin
      tx_state_r <= TX_IDLE;
      tx_shreg_r <= 8'h00;
      tx_bit_r   <= 3'd0;
      tx_lead_r  <= 1'b0;
      tx_r       <= 1'b1;
      tx_busy_r  <= 1'b0;
    end else begin
      tx_state_r <= tx_state_nxt_s;
      tx_shreg_r <= tx_shreg_nxt_s;
      tx_bit_r   <= tx_bit_nxt_s;
      tx_lead_r  <= tx_lead_nxt_s;
      tx_r       <= tx_nxt_s;
      tx_busy_r  <= tx_busy_nxt_s;
    end
  end

  // TX next state; START first waits for a tick, then holds the start bit one bit time
  always_comb begin
    tx_state_nxt_s = tx_state_r;
    tx_shreg_nxt_s = tx_shreg_r;
    tx_bit_nxt_s   = tx_bit_r;
    tx_lead_nxt_s  = tx_lead_r;
    tx_nxt_s       = tx_r;
    tx_busy_nxt_s  = tx_busy_r;
    case (tx_state_r)
      TX_IDLE: begin
        if (wr_en) begin
          tx_state_nxt_s = TX_START;
          tx_shreg_nxt_s = din;
          tx_lead_nxt_s  = 1'b0;
          tx_busy_nxt_s  = 1'b1;
        end else begin
          tx_nxt_s = 1'b1;
        end
      end
      TX_START: begin
        if (tx_tick_s && !tx_lead_r) begin
          tx_nxt_s      = 1'b0;
          tx_lead_nxt_s = 1'b1;
        end else if (tx_tick_s) begin
          tx_nxt_s       = tx_shreg_r[0];
          tx_shreg_nxt_s = {1'b0, tx_shreg_r[7:1]};
          tx_bit_nxt_s   = 3'd0;
          tx_state_nxt_s = TX_DATA;
        end else begin
          tx_lead_nxt_s = tx_lead_r;
        end
      end
      TX_DATA: begin
        if (tx_tick_s && (tx_bit_r == 3'd7)) begin
          tx_nxt_s       = 1'b1;
          tx_state_nxt_s = TX_STOP;
        end else if (tx_tick_s) begin
          tx_nxt_s       = tx_shreg_r[0];
          tx_shreg_nxt_s = {1'b0, tx_shreg_r[7:1]};
          tx_bit_nxt_s   = tx_bit_r + 3'd1;
        end else begin
          tx_bit_nxt_s = tx_bit_r;
        end
      end
      TX_STOP: begin
        if (tx_tick_s) begin
          tx_state_nxt_s = TX_IDLE;
          tx_busy_nxt_s  = 1'b0;
        end else begin
          tx_busy_nxt_s = 1'b1;
        end
      end
      default: begin
        tx_state_nxt_s = TX_IDLE;
        tx_nxt_s       = 1'b1;
        tx_busy_nxt_s  = 1'b0;
      end
    endcase
  end

  // RX synchronizer, state and received-byte registers
  always_ff @(posedge clock) begin
    if (!reset) begin
      rx_meta_r  <= 1'b1;
      rx_sync_r  <= 1'b1;
      rx_state_r <= RX_IDLE;
      rx_tcnt_r  <= 4'd0;
      rx_bit_r   <= 3'd0;
      rx_shreg_r <= 8'h00;
      dout_r     <= 8'h00;
      rdy_r      <= 1'b0;
    end else begin
      rx_meta_r  <= rx;
      rx_sync_r  <= rx_meta_r;
      rx_state_r <= rx_state_nxt_s;
      rx_tcnt_r  <= rx_tcnt_nxt_s;
      rx_bit_r   <= rx_bit_nxt_s;
      rx_shreg_r <= rx_shreg_nxt_s;
      if (rx_done_s) begin
        dout_r <= rx_shreg_r;
        rdy_r  <= 1'b1;
      end else if (rdy_clr) begin
        rdy_r  <= 1'b0;
      end else begin
        rdy_r  <= rdy_r;
      end
    end
  end

  // RX next state; samples at mid-bit using 16x oversampling ticks
  always_comb begin
    rx_state_nxt_s = rx_state_r;
    rx_tcnt_nxt_s  = rx_tcnt_r;
    rx_bit_nxt_s   = rx_bit_r;
    rx_shreg_nxt_s = rx_shreg_r;
    rx_done_s      = 1'b0;
    case (rx_state_r)
      RX_IDLE: begin
        if (rx_tick_s && !rx_sync_r) begin
          rx_state_nxt_s = RX_START;
          rx_tcnt_nxt_s  = 4'd0;
        end else begin
          rx_tcnt_nxt_s = 4'd0;
        end
      end
      RX_START: begin
        if (rx_tick_s && (rx_tcnt_r == 4'd7)) begin
          rx_tcnt_nxt_s  = 4'd0;
          rx_bit_nxt_s   = 3'd0;
          rx_state_nxt_s = rx_sync_r ? RX_IDLE : RX_DATA;
        end else if (rx_tick_s) begin
          rx_tcnt_nxt_s = rx_tcnt_r + 4'd1;
        end else begin
          rx_tcnt_nxt_s = rx_tcnt_r;
        end
      end
      RX_DATA: begin
        if (rx_tick_s && (rx_tcnt_r == 4'd15)) begin
          rx_tcnt_nxt_s  = 4'd0;
          rx_shreg_nxt_s = {rx_sync_r, rx_shreg_r[7:1]};
          rx_bit_nxt_s   = rx_bit_r + 3'd1;
          rx_state_nxt_s = (rx_bit_r == 3'd7) ? RX_STOP : RX_DATA;
        end else if (rx_tick_s) begin
          rx_tcnt_nxt_s = rx_tcnt_r + 4'd1;
        end else begin
          rx_tcnt_nxt_s = rx_tcnt_r;
        end
      end
      RX_STOP: begin
        if (rx_tick_s && (rx_tcnt_r == 4'd15)) begin
          rx_tcnt_nxt_s  = 4'd0;
          rx_state_nxt_s = RX_IDLE;
          rx_done_s      = rx_sync_r;
        end else if (rx_tick_s) begin
          rx_tcnt_nxt_s = rx_tcnt_r + 4'd1;
        end else begin
          rx_tcnt_nxt_s = rx_tcnt_r;
        end
      end
      default: begin
        rx_state_nxt_s = RX_IDLE;
        rx_tcnt_nxt_s  = 4'd0;
      end
    endcase
  end

  generate
    if (SR_INPUT_WIDTH == SR_DATA_WIDTH) begin : g_sr_parallel
      assign sr_load_val_s = sr_in;
    end else begin : g_sr_append
      assign sr_load_val_s = {sr_r[SR_DATA_WIDTH-SR_INPUT_WIDTH-1:0], sr_in};
    end
  endgenerate

  // Staging shift register: load/append wins over shift
  always_ff @(posedge clock) begin
    if (!reset) begin
      sr_r <= '0;
    end else if (sr_load) begin
      sr_r <= sr_load_val_s;
    end else if (sr_shift) begin
      sr_r <= sr_r << SR_SHIFT_WIDTH;
    end else begin
      sr_r <= sr_r;
    end
  end

  assign tx      = tx_r;
  assign tx_busy = tx_busy_r;
  assign rdy     = rdy_r;
  assign dout    = dout_r;
  assign sr_out  = sr_r;

endmodule

// File: tb/tb_uart_shift_link.sv
// Self-checking bench for uart_shift_link: reset, TX framing, loopback RX with a
// scoreboard, glitch rejection, framing error and both shift-register shapes.
module tb_uart_shift_link;

  logic         clock = 1'b0;
  logic         reset;
  logic [7:0]   din;
  logic         wr_en;
  logic         tx;
  logic         tx_busy;
  logic         rx;
  logic         rx_drv;
  logic         loop_en;
  logic         rdy;
  logic         rdy_clr;
  logic [7:0]   dout;
  logic [31:0]  sr_in;
  logic         sr_load;
  logic         sr_shift;
  logic [31:0]  sr_out;

  logic         h_tx, h_tx_busy, h_rdy;
  logic [7:0]   h_dout;
  logic [7:0]   h_sr_in;
  logic         h_sr_load;
  logic [639:0] h_sr_out;

  int checks = 0;
  int errors = 0;
  logic [7:0] exp_q[$];

  always #5 clock = ~clock;

  assign rx = loop_en ? tx : rx_drv;

  uart_shift_link dut (
    .clock(clock), .reset(reset), .din(din), .wr_en(wr_en), .tx(tx), .tx_busy(tx_busy),
    .rx(rx), .rdy(rdy), .rdy_clr(rdy_clr), .dout(dout),
    .sr_in(sr_in), .sr_load(sr_load), .sr_shift(sr_shift), .sr_out(sr_out)
  );

  uart_shift_link #(.SR_INPUT_WIDTH(8), .SR_DATA_WIDTH(640), .SR_SHIFT_WIDTH(8)) dut_hdr (
    .clock(clock), .reset(reset), .din(8'h00), .wr_en(1'b0), .tx(h_tx), .tx_busy(h_tx_busy),
    .rx(1'b1), .rdy(h_rdy), .rdy_clr(1'b0), .dout(h_dout),
    .sr_in(h_sr_in), .sr_load(h_sr_load), .sr_shift(1'b0), .sr_out(h_sr_out)
  );

  task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_idle();
    int n = 0;
    while (tx_busy && n < 6000) begin
      @(negedge clock);
      n++;
    end
    check_val("tx_idle_timeout", {63'd0, tx_busy}, 64'd0);
  endtask

  task automatic send_byte(input logic [7:0] b);
    wait_idle();
    din   = b;
    wr_en = 1'b1;
    @(negedge clock);
    wr_en = 1'b0;
  endtask

  task automatic expect_rx();
    int n = 0;
    logic [7:0] e;
    while (!rdy && n < 6000) begin
      @(negedge clock);
      n++;
    end
    check_val("rx_rdy", {63'd0, rdy}, 64'd1);
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check_val("rx_dout", {56'd0, dout}, {56'd0, e});
    end else begin
      check_val("rx_queue_empty", 64'd1, 64'd0);
    end
    rdy_clr = 1'b1;
    @(negedge clock);
    rdy_clr = 1'b0;
    check_val("rdy_clr", {63'd0, rdy}, 64'd0);
  endtask

  initial begin
    logic [9:0]  frame;
    logic [31:0] sr_exp;
    logic        found;
    logic        low_seen;
    logic [7:0]  last_byte;
    logic [7:0]  bad_byte;
    int          n;

    reset = 1'b0; din = 8'h00; wr_en = 1'b0; rx_drv = 1'b1; loop_en = 1'b0;
    rdy_clr = 1'b0; sr_in = 32'h0; sr_load = 1'b0; sr_shift = 1'b0;
    h_sr_in = 8'h00; h_sr_load = 1'b0;
    repeat (2) @(negedge clock);
    check_val("rst_tx", {63'd0, tx}, 64'd1);
    check_val("rst_busy", {63'd0, tx_busy}, 64'd0);
    check_val("rst_rdy", {63'd0, rdy}, 64'd0);
    check_val("rst_dout", {56'd0, dout}, 64'd0);
    check_val("rst_sr", {32'd0, sr_out}, 64'd0);
    check_val("rst_hdr_misc", {52'd0, h_tx, h_tx_busy, h_rdy, h_dout, 1'b0}, {52'd0, 3'b100, 8'h00, 1'b0});
    check_val("rst_hdr_sr", {63'd0, |h_sr_out}, 64'd0);
    reset = 1'b1;
    @(negedge clock);

    // Nonce staging 32/32/8
    sr_in = 32'hDEADBEEF; sr_load = 1'b1;
    @(negedge clock);
    sr_load = 1'b0;
    sr_exp = 32'hDEADBEEF;
    check_val("sr_load", {32'd0, sr_out}, {32'd0, sr_exp});
    check_val("sr_top0", {56'd0, sr_out[31:24]}, 64'hDE);
    @(negedge clock);
    check_val("sr_hold", {32'd0, sr_out}, {32'd0, sr_exp});
    for (int i = 1; i <= 3; i++) begin
      sr_shift = 1'b1;
      @(negedge clock);
      sr_shift = 1'b0;
      sr_exp = sr_exp << 8;
      check_val("sr_top", {56'd0, sr_out[31:24]}, {56'd0, sr_exp[31:24]});
    end
    check_val("sr_final", {32'd0, sr_out}, 64'hEF000000);
    sr_in = 32'h12345678; sr_load = 1'b1; sr_shift = 1'b1;
    @(negedge clock);
    sr_load = 1'b0; sr_shift = 1'b0;
    check_val("sr_load_wins", {32'd0, sr_out}, 64'h12345678);
    sr_shift = 1'b1;
    @(negedge clock);
    sr_shift = 1'b0;
    check_val("sr_shift_zero_fill", {32'd0, sr_out}, 64'h34567800);

    // Header assembly 8/640
    for (int i = 0; i < 80; i++) begin
      h_sr_in = 8'(i + 1); h_sr_load = 1'b1;
      @(negedge clock);
    end
    h_sr_load = 1'b0;
    @(negedge clock);
    check_val("hdr_low", {56'd0, h_sr_out[7:0]}, 64'h50);
    check_val("hdr_high", {56'd0, h_sr_out[639:632]}, 64'h01);
    for (int k = 0; k < 80; k++) begin
      check_val("hdr_byte", {56'd0, h_sr_out[8*k +: 8]}, 64'(80 - k));
    end

    // Transmit 0x55 and check each bit at its middle; second wr_en while busy is dropped
    frame = {1'b1, 8'h55, 1'b0};
    send_byte(8'h55);
    found = 1'b0;
    n = 0;
    while (!found && n < 500) begin
      @(negedge clock);
      found = ~tx;
      n++;
    end
    check_val("tx_start_seen", {63'd0, found}, 64'd1);
    repeat (217) @(negedge clock);
    check_val("tx_bit", {63'd0, tx}, {63'd0, frame[0]});
    for (int i = 1; i < 10; i++) begin
      if (i == 3) begin
        din = 8'h00; wr_en = 1'b1;
        @(negedge clock);
        wr_en = 1'b0;
        repeat (433) @(negedge clock);
      end else begin
        repeat (434) @(negedge clock);
      end
      check_val("tx_bit", {63'd0, tx}, {63'd0, frame[i]});
      if (i == 5) check_val("tx_busy_mid", {63'd0, tx_busy}, 64'd1);
    end
    wait_idle();
    low_seen = 1'b0;
    repeat (1000) begin
      @(negedge clock);
      low_seen = low_seen | ~tx;
    end
    check_val("no_extra_frame", {63'd0, low_seen}, 64'd0);

    // Loopback with scoreboard
    loop_en = 1'b1;
    exp_q.push_back(8'hA5);
    send_byte(8'hA5);
    expect_rx();
    exp_q.push_back(8'h81);
    send_byte(8'h81);
    expect_rx();
    last_byte = 8'h81;
    wait_idle();
    loop_en = 1'b0;
    repeat (500) @(negedge clock);

    // One RX-tick low glitch
    rx_drv = 1'b0;
    repeat (27) @(negedge clock);
    rx_drv = 1'b1;
    repeat (5000) @(negedge clock);
    check_val("glitch_rdy", {63'd0, rdy}, 64'd0);
    check_val("glitch_dout", {56'd0, dout}, {56'd0, last_byte});

    // Framing error: 0x3C with stop bit low for most of the stop bit
    bad_byte = 8'h3C;
    rx_drv = 1'b0;
    repeat (434) @(negedge clock);
    for (int i = 0; i < 8; i++) begin
      rx_drv = bad_byte[i];
      repeat (434) @(negedge clock);
    end
    rx_drv = 1'b0;
    repeat (325) @(negedge clock);
    rx_drv = 1'b1;
    repeat (2000) @(negedge clock);
    check_val("frame_err_rdy", {63'd0, rdy}, 64'd0);
    check_val("frame_err_dout", {56'd0, dout}, {56'd0, last_byte});

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/uart_shift_link.md
# uart_shift_link

Byte-serial link block for the miner front end: an 8N1 UART transceiver plus a parameterised shift register. The shift register stages multi-byte words, such as a 32-bit nonce loaded in parallel or a header assembled from received bytes. Upstream logic feeds bytes to the transmitter one at a time with a ready/busy handshake. All logic runs on a single clock.

## Interface
Parameters:
- CLK_FREQ, 50_000_000: clock frequency in Hz.
- BAUD, 115200: line rate in bit/s.
- SR_INPUT_WIDTH, 32: width of `sr_in`, shifted in per load.
- SR_DATA_WIDTH, 32: width of the shift register; must be a multiple of SR_INPUT_WIDTH and at least SR_SHIFT_WIDTH.
- SR_SHIFT_WIDTH, 8: bits discarded per `sr_shift`.

Ports:
- clock, in, 1: system clock. Single clock domain.
- reset, in, 1: synchronous, active-low reset.
- din, in, 8: byte to transmit.
- wr_en, in, 1: transmit request; `din` is captured when `tx_busy`=0.
- tx, out, 1: serial output; idles high.
- tx_busy, out, 1: transmitter is occupied.
- rx, in, 1: serial input, asynchronous to `clock`.
- rdy, out, 1: a received byte is valid in `dout`.
- rdy_clr, in, 1: clears `rdy`.
- dout, out, 8: last received byte.
- sr_in, in, SR_INPUT_WIDTH: shift-register load data.
- sr_load, in, 1: load/append `sr_in`.
- sr_shift, in, 1: shift out one SR_SHIFT_WIDTH chunk.
- sr_out, out, SR_DATA_WIDTH: shift-register contents.

## Operation
- **Baud generation**
  - TX tick: one pulse every CLK_FREQ/BAUD cycles, integer-truncated (434 at defaults), from a free-running counter.
  - RX tick: one pulse every CLK_FREQ/(16·BAUD) cycles, truncated (27 at defaults), for 16× oversampling.
- **Frame format:** one start bit (0), 8 data bits LSB first, one stop bit (1), no parity.
- **TX state machine:** IDLE → START → DATA(8) → STOP → IDLE.
  - IDLE: when `wr_en`=1, latch `din` and go to START.
  - Each subsequent state change happens on a TX tick.
  - `wr_en` while `tx_busy`=1 is ignored; the byte is dropped.
- **RX path**
  - `rx` passes through a 2-flop synchronizer.
  - RX state machine: IDLE → START → DATA → STOP, stepping on RX ticks.
  - IDLE→START when the synchronized line is seen low.
  - START: after 8 RX ticks, re-sample the line. If it is high, treat as a glitch and return to IDLE; if low, go to DATA.
  - DATA: take one sample every 16 RX ticks, so each bit is sampled at mid-bit; 8 bits, LSB first.
  - STOP: sample once, 16 RX ticks after the last data bit.
    - Stop bit = 1: update `dout` and set `rdy`.
    - Stop bit = 0 (framing error): discard the byte; `dout` and `rdy` are unchanged.
  - Return to IDLE after the stop sample.
- **rdy handshake**
  - `rdy` stays high until a cycle with `rdy_clr`=1; it clears on the next edge.
  - Byte completion in the same cycle as `rdy_clr`: completion wins and `rdy` stays 1.
  - Overrun (a new byte while `rdy`=1): `dout` is overwritten and `rdy` stays 1.
- **Shift register**, updated on the clock edge:
  - `sr_load`=1: `sr_out` ← {`sr_out`[SR_DATA_WIDTH-SR_INPUT_WIDTH-1:0], `sr_in`}. This is a parallel load when SR_INPUT_WIDTH equals SR_DATA_WIDTH.
  - Otherwise, `sr_shift`=1: `sr_out` ← `sr_out` << SR_SHIFT_WIDTH, zero-filled.
  - `sr_load` has priority when both are high; the register holds when neither is high.
  - After a load, the most significant byte (`sr_out`[top:top-7]) is the next byte to send.

## Timing
- **Reset (`reset`=0 at an edge)**
  - `tx`=1, `tx_busy`=0, `rdy`=0, `dout`=0, `sr_out`=0.
  - Both state machines go to IDLE; the baud counters clear.
  - Reset mid-frame aborts the frame immediately.
- **Transmit**
  - `tx_busy` rises on the edge that samples `wr_en` and falls on the TX tick that ends the stop bit.
  - The start bit begins at the next TX tick: 1–434 cycles of latency at defaults.
  - Each bit lasts 434 cycles; the frame is 4340 cycles.
  - A new `wr_en` is accepted in the first cycle after `tx_busy` falls.
- **Receive:** `rdy` rises within one RX tick of the stop-bit mid-sample, about 9.5 bit times after the falling edge of the start bit.
- **Shift register:** one-cycle latency, no combinational path from inputs to `sr_out`.

## Test plan
- Reset values: assert `reset`=0 for 2 cycles → `tx`=1, `tx_busy`=0, `rdy`=0, `dout`=0x00, `sr_out`=0.
- Transmit 0x55: `wr_en` pulse with `din`=0x55 → `tx` shows 0,1,0,1,0,1,0,1,0,1 with 434 cycles per bit. A second `wr_en` while busy produces no extra frame.
- Loopback: `tx` tied to `rx`, send 0xA5 → `rdy`=1 with `dout`=0xA5; `rdy_clr` pulse → `rdy`=0 on the next cycle. A 1-RX-tick low glitch on `rx` produces no `rdy`.
- Framing error: drive an `rx` frame for 0x3C with stop bit = 0 → `rdy` stays 0 and `dout` is unchanged.
- Nonce staging (32/32/8): load 0xDEADBEEF, then 3 shifts → top byte reads 0xDE, 0xAD, 0xBE, 0xEF in turn, and `sr_out`=0xEF000000. Load and shift together → load wins.
- Header assembly (input 8, data 640): 80 loads of bytes 0x01..0x50 → `sr_out`[7:0]=0x50 and `sr_out`[639:632]=0x01.
